// File: rtl/router_pkg.sv
// Shared router definitions: flit flag positions and credit_tx states.
package router_pkg;

  localparam int TAIL_OFS = 1;
  localparam int HEAD_OFS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } tx_state_t;

endpackage

// File: rtl/credit_tx_counter.sv
// Up/down credit counter bounded at credit_max with sticky overflow flag.
module credit_counter #(
  parameter int credit_max = 8,
  parameter int CW = $clog2(credit_max + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          err
);

  logic [CW-1:0] r_count;
  logic          r_err;
  logic          w_full;

  assign w_full = (r_count == CW'(credit_max));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= CW'(credit_max);
      r_err   <= 1'b0;
    end else if (inc && !dec) begin
      if (w_full) r_err <= 1'b1;
      else        r_count <= r_count + CW'(1);
    end else if (dec && !inc) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign count = r_count;
  assign err   = r_err;

endmodule

// File: rtl/credit_tx.sv
// Credit-based packet transmitter toward a downstream link.
// Optional counters enabled by CREDIT_TX_STATS_EN.
module credit_tx
  import router_pkg::*;
#(
  parameter int buffer_width = 64,
  parameter int credit_max   = 8,
  parameter int CW = $clog2(credit_max + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [buffer_width-1:0] fifo_out,
  input  logic                    fifo_empty,
  output logic                    fifo_consume,
  output logic                    link_req,
  input  logic                    link_grant,
  output logic [buffer_width-1:0] tx_flit,
  output logic                    tx_valid,
  input  logic                    credit_in,
  output logic [CW-1:0]           credit_count,
`ifdef CREDIT_TX_STATS_EN
  output logic [31:0]             stat_flits,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_stall,
`endif
  output logic                    credit_err
);

  tx_state_t r_state, w_next;
  logic      w_head, w_tail, w_credit;
  logic      w_send, w_drop, w_req;

  assign w_head   = fifo_out[buffer_width-HEAD_OFS];
  assign w_tail   = fifo_out[buffer_width-TAIL_OFS];
  assign w_credit = (credit_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_send = 1'b0;
    w_drop = 1'b0;
    w_req  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          if (w_head) w_next = REQ;
          else        w_drop = 1'b1;
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (link_grant && w_credit && !fifo_empty) begin
          w_send = 1'b1;
          w_next = w_tail ? IDLE : XFER;
        end
      end
      XFER: begin
        w_req = 1'b1;
        if (w_credit && !fifo_empty) begin
          w_send = 1'b1;
          if (w_tail) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Gate with rst so a queued non-head flit is not dropped during reset.
  assign fifo_consume = (w_send | w_drop) & rst;
  assign link_req     = w_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_flit  <= '0;
    end else begin
      tx_valid <= w_send;
      if (w_send) tx_flit <= fifo_out;
    end
  end

  credit_counter #(
    .credit_max (credit_max),
    .CW         (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (credit_in),
    .dec   (w_send),
    .count (credit_count),
    .err   (credit_err)
  );

`ifdef CREDIT_TX_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_flits <= '0;
      stat_pkts  <= '0;
      stat_stall <= '0;
    end else begin
      if (w_send)               stat_flits <= stat_flits + 32'd1;
      if (w_send && w_tail)     stat_pkts  <= stat_pkts + 32'd1;
      if (r_state == XFER && !w_send)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_credit_tx.sv
// Directed vector bench for credit_tx (credit_max 8 and 2 instances).
module tb_credit_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] fo;
  logic        emp, gnt, cin;
  logic        cons, lreq, tv, err;
  logic [63:0] txf;
  logic [3:0]  cc;

  logic        b_rst = 1'b0;
  logic [63:0] b_fo;
  logic        b_emp, b_gnt, b_cin;
  logic        b_cons, b_lreq, b_tv, b_err;
  logic [63:0] b_txf;
  logic [1:0]  b_cc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  credit_tx dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_out     (fo),
    .fifo_empty   (emp),
    .fifo_consume (cons),
    .link_req     (lreq),
    .link_grant   (gnt),
    .tx_flit      (txf),
    .tx_valid     (tv),
    .credit_in    (cin),
    .credit_count (cc),
    .credit_err   (err)
  );

  credit_tx #(.credit_max(2)) dut2 (
    .clk          (clk),
    .rst          (b_rst),
    .fifo_out     (b_fo),
    .fifo_empty   (b_emp),
    .fifo_consume (b_cons),
    .link_req     (b_lreq),
    .link_grant   (b_gnt),
    .tx_flit      (b_txf),
    .tx_valid     (b_tv),
    .credit_in    (b_cin),
    .credit_count (b_cc),
    .credit_err   (b_err)
  );

  typedef struct {
    logic       rst, emp, hd, tl, gnt, cin;
    logic [7:0] d;
    logic       c, lr, tv;
    logic [3:0] cc;
    logic       err;
  } vec_t;

  vec_t vt[$];

  function automatic logic [63:0] mk(logic hd, logic tl, logic [7:0] d);
    return {tl, hd, 54'd0, d};
  endfunction

  function automatic vec_t v(logic r, logic e, logic h, logic t,
                             logic g, logic ci, logic [7:0] d,
                             logic c, logic lr, logic tvv,
                             logic [3:0] ccv, logic er);
    vec_t x;
    x.rst = r; x.emp = e; x.hd = h; x.tl = t; x.gnt = g; x.cin = ci;
    x.d = d; x.c = c; x.lr = lr; x.tv = tvv; x.cc = ccv; x.err = er;
    return x;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic [63:0] last;

  initial begin
    fo = '0; emp = 1'b1; gnt = 1'b0; cin = 1'b0;
    b_fo = '0; b_emp = 1'b1; b_gnt = 1'b0; b_cin = 1'b0;
    last = '0;

    //        rst emp hd tl gnt cin d      c  lr tv cc err
    vt.push_back(v(0,0,0,0,0,0,8'h00, 0,0,0,8,0));
    vt.push_back(v(1,0,1,0,0,0,8'hA1, 0,0,0,8,0));
    vt.push_back(v(1,0,1,0,1,0,8'hA1, 1,1,1,7,0));
    vt.push_back(v(1,0,0,0,1,0,8'hB2, 1,1,1,6,0));
    vt.push_back(v(1,0,0,1,1,0,8'hC3, 1,1,1,5,0));
    vt.push_back(v(1,1,0,0,1,0,8'h00, 0,0,0,5,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,6,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,7,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,8,0));
    vt.push_back(v(1,0,1,1,1,0,8'hD4, 0,0,0,8,0));
    vt.push_back(v(1,0,1,1,1,0,8'hD4, 1,1,1,7,0));
    vt.push_back(v(1,1,0,0,0,0,8'h00, 0,0,0,7,0));
    vt.push_back(v(1,0,0,0,0,0,8'hE5, 1,0,0,7,0));
    vt.push_back(v(1,1,0,0,0,0,8'h00, 0,0,0,7,0));
    vt.push_back(v(1,0,1,0,0,0,8'h11, 0,0,0,7,0));
    vt.push_back(v(1,0,1,0,0,0,8'h11, 0,1,0,7,0));
    vt.push_back(v(1,0,1,0,1,0,8'h11, 1,1,1,6,0));
    vt.push_back(v(1,0,0,0,0,0,8'h12, 1,1,1,5,0));
    vt.push_back(v(1,0,0,0,0,0,8'h13, 1,1,1,4,0));
    vt.push_back(v(1,0,0,0,0,1,8'h14, 1,1,1,4,0));
    vt.push_back(v(1,1,0,0,0,0,8'h00, 0,1,0,4,0));
    vt.push_back(v(1,0,0,1,0,0,8'h15, 1,1,1,3,0));
    vt.push_back(v(1,1,0,0,0,0,8'h00, 0,0,0,3,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,4,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,5,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,6,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,7,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,8,0));
    vt.push_back(v(1,1,0,0,0,1,8'h00, 0,0,0,8,1));

    @(posedge clk); #1;
    foreach (vt[i]) begin
      rst = vt[i].rst; emp = vt[i].emp; gnt = vt[i].gnt; cin = vt[i].cin;
      fo  = mk(vt[i].hd, vt[i].tl, vt[i].d);
      #1;
      chk($sformatf("v%0d consume", i), 64'(cons), 64'(vt[i].c));
      chk($sformatf("v%0d link_req", i), 64'(lreq), 64'(vt[i].lr));
      @(posedge clk); #1;
      if (vt[i].tv) last = mk(vt[i].hd, vt[i].tl, vt[i].d);
      chk($sformatf("v%0d tx_valid", i), 64'(tv), 64'(vt[i].tv));
      chk($sformatf("v%0d tx_flit", i), txf, last);
      chk($sformatf("v%0d credits", i), 64'(cc), 64'(vt[i].cc));
      chk($sformatf("v%0d credit_err", i), 64'(err), 64'(vt[i].err));
    end

    // Reset during the 2nd flit of a packet
    rst = 1'b0; #1; rst = 1'b1;
    emp = 1'b0; gnt = 1'b1; cin = 1'b0; fo = mk(1, 0, 8'h21);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid head sent", 64'(tv), 64'd1);
    fo = mk(0, 0, 8'h22); #1;
    chk("mid body consume", 64'(cons), 64'd1);
    rst = 1'b0; #1;
    chk("rst consume", 64'(cons), 64'd0);
    chk("rst link_req", 64'(lreq), 64'd0);
    chk("rst tx_valid", 64'(tv), 64'd0);
    chk("rst tx_flit", txf, 64'd0);
    chk("rst credits", 64'(cc), 64'd8);
    chk("rst credit_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    chk("rst hold consume", 64'(cons), 64'd0);
    emp = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("post rst consume", 64'(cons), 64'd0);
    chk("post rst tx_valid", 64'(tv), 64'd0);
    emp = 1'b0; fo = mk(1, 0, 8'h31); #1;
    chk("new head no consume", 64'(cons), 64'd0);
    @(posedge clk); #1;
    chk("new head link_req", 64'(lreq), 64'd1);
    chk("new head consume", 64'(cons), 64'd1);

    // credit_max=2, 4-flit packet, credit starvation
    b_rst = 1'b1; b_emp = 1'b0; b_gnt = 1'b1; b_fo = mk(1, 0, 8'h41);
    @(posedge clk); #1;
    chk("c2 req", 64'(b_lreq), 64'd1);
    @(posedge clk); #1;
    chk("c2 f0 valid", 64'(b_tv), 64'd1);
    chk("c2 f0 credits", 64'(b_cc), 64'd1);
    b_fo = mk(0, 0, 8'h42);
    @(posedge clk); #1;
    chk("c2 f1 valid", 64'(b_tv), 64'd1);
    chk("c2 f1 credits", 64'(b_cc), 64'd0);
    b_fo = mk(0, 0, 8'h43); #1;
    chk("c2 stall consume", 64'(b_cons), 64'd0);
    chk("c2 stall link_req", 64'(b_lreq), 64'd1);
    @(posedge clk); #1;
    chk("c2 stall valid", 64'(b_tv), 64'd0);
    chk("c2 stall flit hold", b_txf, mk(0, 0, 8'h42));
    b_cin = 1'b1; #1;
    chk("c2 cin consume", 64'(b_cons), 64'd0);
    @(posedge clk); #1;
    b_cin = 1'b0;
    chk("c2 cin credits", 64'(b_cc), 64'd1);
    #1;
    chk("c2 f2 consume", 64'(b_cons), 64'd1);
    @(posedge clk); #1;
    chk("c2 f2 valid", 64'(b_tv), 64'd1);
    chk("c2 f2 flit", b_txf, mk(0, 0, 8'h43));
    chk("c2 f2 credits", 64'(b_cc), 64'd0);
    chk("c2 credit_err", 64'(b_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/credit_tx.md
CREDIT_TX -- requirements
Module: credit_tx

Interface
REQ-001 Parameter buffer_width SHALL default to 64 and set the flit width, with bit [buffer_width-1] as the tail flag and bit [buffer_width-2] as the head flag.
REQ-002 Parameter credit_max SHALL default to 8 and equal the downstream buffer depth, which is also the reset credit count.
REQ-003 Port clk, input, 1 bit: the only clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-005 Port fifo_out, input, buffer_width: show-ahead head-of-queue flit from the upstream buffer.
REQ-006 Port fifo_empty, input, 1 bit: upstream buffer empty.
REQ-007 Port fifo_consume, output, 1 bit: combinational pop strobe to the upstream buffer.
REQ-008 Port link_req, output, 1 bit: output-port request to the switch arbiter.
REQ-009 Port link_grant, input, 1 bit: arbiter grant, meaningful only while link_req=1.
REQ-010 Port tx_flit, output, buffer_width: registered flit to the downstream link.
REQ-011 Port tx_valid, output, 1 bit: registered; tx_flit is valid this cycle.
REQ-012 Port credit_in, input, 1 bit: one credit returned per cycle when high.
REQ-013 Port credit_count, output, $clog2(credit_max+1) bits: current credits.
REQ-014 Port credit_err, output, 1 bit: sticky flag for credit overflow.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and XFER.
REQ-016 IDLE: if !fifo_empty and the head flag is set, go to REQ; if !fifo_empty and the head flag is clear, pulse fifo_consume to discard the flit and stay in IDLE.
REQ-017 REQ: link_req=1; when link_grant && credit_count>0 && !fifo_empty, send a flit, then go to IDLE if that flit is the tail, else to XFER.
REQ-018 XFER: link_req SHALL stay 1; send a flit in any cycle with !fifo_empty && credit_count>0; stall otherwise; return to IDLE after sending the tail flit.
REQ-019 In this block, "send" SHALL mean: fifo_consume=1 in the same cycle, and fifo_out is captured into tx_flit with tx_valid=1 on the next edge (latency 1).
REQ-020 When no flit is sent in a cycle, tx_valid SHALL be 0 on the next edge and tx_flit SHALL hold its value.
REQ-021 fifo_consume SHALL never be asserted while fifo_empty=1.
REQ-022 Credits SHALL decrement by 1 per send and increment by 1 per credit_in.
REQ-023 A send and a credit_in in the same cycle SHALL leave credit_count unchanged.
REQ-024 A credit_in at credit_count=credit_max with no send SHALL be ignored and SHALL set credit_err.
REQ-025 A send SHALL never occur at credit_count=0, so the credit count cannot underflow.
REQ-026 A flit carrying both head and tail flags SHALL be a complete packet: REQ to IDLE in one send.
REQ-027 link_req SHALL deassert in the cycle after the tail flit is sent.

Reset
REQ-028 While rst=0, the block SHALL be in state IDLE with credit_count=credit_max, and link_req, tx_valid, tx_flit, credit_err and fifo_consume all 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet immediately, with no further consume.
REQ-030 After reset release, the first action SHALL occur on the first clk edge at which rst=1.

Configuration
REQ-031 Macro CREDIT_TX_STATS_EN SHALL control the statistics feature.
REQ-032 When CREDIT_TX_STATS_EN is defined, the block SHALL add three 32-bit outputs, all reset to 0 and wrapping on overflow:
- stat_flits: flits sent
- stat_pkts: tail flits sent
- stat_stall: XFER cycles with no send
REQ-033 When CREDIT_TX_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 The shared package router_pkg SHALL hold:
- the flit flag bit-position constants
- the credit_tx state enum (IDLE/REQ/XFER)
REQ-035 Sub-module credit_counter SHALL implement the up/down saturating counter and credit_err, and credit_tx SHALL instantiate it once.

Verification
REQ-036 3-flit packet (head, body, tail) queued, grant held, credits=8 -> tx_valid for 3 consecutive cycles, credit_count=5, link_req drops after the tail.
REQ-037 Single head+tail flit -> one tx_valid, state returns to IDLE, credit_count=7.
REQ-038 credit_max=2 and a 4-flit packet with no credit_in -> 2 flits sent, XFER stalls; one credit_in -> the 3rd flit is sent the next cycle.
REQ-039 Simultaneous send and credit_in at credit_count=4 -> credit_count stays 4; credit_in at 8 with no send -> stays 8 and credit_err=1.
REQ-040 A non-head flit at the queue front in IDLE -> discarded with one consume, no tx_valid, no link_req.
REQ-041 rst driven low during the 2nd flit of a packet -> outputs 0 and credit_count=8 asynchronously, and no consume until the next head flit.
